// File: rtl/fifo_serializer_if.sv
// Read-side handshake between the byte FIFO and the serializer that drains it.
// Handshake: READ is a one-cycle request qualified by !FIFO_EMPTY; the FIFO answers
// with FIFO_VALID=1 and FIFO_DATA on the very next cycle, and never otherwise.
interface fifo_serializer_if #(
    parameter int DATA_W = 8
);
    logic              FIFO_EMPTY;
    logic [DATA_W-1:0] FIFO_DATA;
    logic              FIFO_VALID;
    logic              READ;

    modport master (
        input  FIFO_EMPTY,
        input  FIFO_DATA,
        input  FIFO_VALID,
        output READ
    );

    modport slave (
        output FIFO_EMPTY,
        output FIFO_DATA,
        output FIFO_VALID,
        input  READ
    );
endinterface

// File: rtl/fifo_serializer.sv
// Drains the byte FIFO and shifts bytes out MSB first, filling empty symbol slots with
// IDLE_SYM; the next byte is fetched at bit DATA_W-2 so consecutive bytes are gapless.
module fifo_serializer #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] IDLE_SYM = 8'hBC
) (
    input  logic                      CLK,
    input  logic                      RESET_L,
    fifo_serializer_if.master         fifo,
    input  logic                      PAUSE,
    output logic                      SERIAL_OUT,
    output logic                      DATA_ACTIVE,
    output logic                      BYTE_DONE,
    output logic                      ERR,
    output logic [$clog2(DATA_W)-1:0] DBG_CNT,
    output logic                      DBG_PEND,
    output logic                      DBG_MODE
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_W - 1);
    localparam logic [CW-1:0] CNT_FETCH = CW'(DATA_W - 2);

    typedef enum logic {
        MODE_IDLE = 1'b0,
        MODE_DATA = 1'b1
    } mode_e;

    mode_e             mode_q, mode_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              read_req;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            mode_q <= MODE_IDLE;
            cnt_q  <= '0;
            sr_q   <= IDLE_SYM;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        sr_d     = {sr_q[DATA_W-2:0], 1'b0};
        mode_d   = mode_q;
        pend_d   = pend_q;
        err_d    = err_q;
        // RESET_L term keeps READ low while reset is held, whatever cnt reads.
        read_req = (cnt_q == CNT_FETCH) && !fifo.FIFO_EMPTY && !PAUSE && RESET_L;

        if (cnt_q == CNT_FETCH) begin
            pend_d = read_req;
        end

        if (cnt_q == CNT_LAST) begin
            pend_d = 1'b0;
            if (pend_q && fifo.FIFO_VALID) begin
                sr_d   = fifo.FIFO_DATA;
                mode_d = MODE_DATA;
            end else begin
                sr_d   = IDLE_SYM;
                mode_d = MODE_IDLE;
            end
        end

        // Unsolicited data is dropped; a missing answer costs the byte. Both are sticky.
        if (fifo.FIFO_VALID && !pend_q) begin
            err_d = 1'b1;
        end
        if (pend_q && (cnt_q == CNT_LAST) && !fifo.FIFO_VALID) begin
            err_d = 1'b1;
        end
    end

    assign fifo.READ   = read_req;
    assign SERIAL_OUT  = sr_q[DATA_W-1];
    assign DATA_ACTIVE = (mode_q == MODE_DATA);
    assign BYTE_DONE   = (cnt_q == CNT_LAST) && (mode_q == MODE_DATA);
    assign ERR         = err_q;
    assign DBG_CNT     = cnt_q;
    assign DBG_PEND    = pend_q;
    assign DBG_MODE    = mode_q;
endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: a table of symbol periods with hand-written expected symbols,
// a hand sequence for reset in mid-byte, and a byte monitor checked against exp_q.
module tb_fifo_serializer;
    logic       CLK = 1'b0;
    logic       RESET_L;
    logic       PAUSE;
    logic       SERIAL_OUT, DATA_ACTIVE, BYTE_DONE, ERR;
    logic [2:0] DBG_CNT;
    logic       DBG_PEND, DBG_MODE;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    always #5 CLK = ~CLK;

    fifo_serializer_if #(.DATA_W(8)) fifo ();

    fifo_serializer #(.DATA_W(8), .IDLE_SYM(8'hBC)) dut (
        .CLK        (CLK),
        .RESET_L    (RESET_L),
        .fifo       (fifo.master),
        .PAUSE      (PAUSE),
        .SERIAL_OUT (SERIAL_OUT),
        .DATA_ACTIVE(DATA_ACTIVE),
        .BYTE_DONE  (BYTE_DONE),
        .ERR        (ERR),
        .DBG_CNT    (DBG_CNT),
        .DBG_PEND   (DBG_PEND),
        .DBG_MODE   (DBG_MODE)
    );

    // One record per 8-cycle symbol period: inputs applied and the outputs expected in it.
    typedef struct {
        logic       rst;        // reset before this period
        logic       empty;
        logic       pause6;     // PAUSE at cnt 6
        logic       pause_oth;  // PAUSE at every other cnt
        logic       valid7;     // FIFO answers at cnt 7
        logic [7:0] data7;
        logic       spur;       // unsolicited FIFO_VALID (8'h3C) at cnt 3
        logic [7:0] sym;        // symbol expected on SERIAL_OUT this period
        logic       act;
        logic       rd;         // READ expected at cnt 6
        logic       err;        // ERR expected at cnt 0
    } per_t;

    per_t tbl[$];

    function automatic per_t mk(logic rst, logic empty, logic pause6, logic pause_oth,
                                logic valid7, logic [7:0] data7, logic spur,
                                logic [7:0] sym, logic act, logic rd, logic err);
        per_t p;
        p.rst = rst; p.empty = empty; p.pause6 = pause6; p.pause_oth = pause_oth;
        p.valid7 = valid7; p.data7 = data7; p.spur = spur;
        p.sym = sym; p.act = act; p.rd = rd; p.err = err;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET_L         = 1'b0;
        PAUSE           = 1'b0;
        fifo.FIFO_EMPTY = 1'b0;
        fifo.FIFO_VALID = 1'b0;
        fifo.FIFO_DATA  = 8'h00;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_serial", 32'(SERIAL_OUT), 32'd1);
        chk("rst_active", 32'(DATA_ACTIVE), 32'd0);
        chk("rst_read", 32'(fifo.READ), 32'd0);
        chk("rst_done", 32'(BYTE_DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        @(negedge CLK);
        RESET_L = 1'b1;
    endtask

    // Runs the first ncyc cycles of a period; only full periods queue their byte.
    task automatic run_period(input per_t p, input int ncyc, input int idx);
        logic [7:0] sym;
        sym = p.sym;
        for (int i = 0; i < ncyc; i++) begin
            fifo.FIFO_EMPTY = p.empty;
            PAUSE           = (i == 6) ? p.pause6 : p.pause_oth;
            if (i == 7 && p.valid7) begin
                fifo.FIFO_VALID = 1'b1;
                fifo.FIFO_DATA  = p.data7;
            end else if (i == 3 && p.spur) begin
                fifo.FIFO_VALID = 1'b1;
                fifo.FIFO_DATA  = 8'h3C;
            end else begin
                fifo.FIFO_VALID = 1'b0;
                fifo.FIFO_DATA  = 8'($urandom_range(0, 255));
            end
            if (i == 0 && p.act && ncyc == 8) exp_q.push_back(sym);
            #1;
            chk($sformatf("p%0d c%0d cnt", idx, i), 32'(DBG_CNT), 32'(i));
            chk($sformatf("p%0d c%0d serial", idx, i), 32'(SERIAL_OUT), 32'(sym[7-i]));
            chk($sformatf("p%0d c%0d active", idx, i), 32'(DATA_ACTIVE), 32'(p.act));
            chk($sformatf("p%0d c%0d done", idx, i), 32'(BYTE_DONE), 32'(i == 7 && p.act));
            chk($sformatf("p%0d c%0d read", idx, i), 32'(fifo.READ), 32'(i == 6 && p.rd));
            if (i == 0) chk($sformatf("p%0d err", idx), 32'(ERR), 32'(p.err));
            @(negedge CLK);
        end
        fifo.FIFO_VALID = 1'b0;
    endtask

    // Byte monitor: rebuilds each data byte from the line and matches it against exp_q.
    initial begin
        logic [7:0] acc;
        acc = 8'h00;
        forever begin
            @(negedge CLK);
            #2;
            if (RESET_L && DATA_ACTIVE) begin
                acc = {acc[6:0], SERIAL_OUT};
                if (BYTE_DONE) begin
                    if (exp_q.size() == 0) begin
                        chk("mon_unexpected_byte", 32'(acc), 32'h1FF);
                    end else begin
                        chk("mon_byte", 32'(acc), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        per_t p;
        int   idx;
        RESET_L         = 1'b0;
        PAUSE           = 1'b0;
        fifo.FIFO_EMPTY = 1'b1;
        fifo.FIFO_VALID = 1'b0;
        fifo.FIFO_DATA  = 8'h00;

        //              rst empty p6 poth v7 data  spur sym    act rd err
        // empty FIFO: idle symbols only
        tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 0, 8'hBC, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'hBC, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'hBC, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'hBC, 0, 0, 0));
        // single byte A5
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hA5, 0, 8'hBC, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'hA5, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'hBC, 0, 0, 0));
        // AA, BB, CC back to back
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hAA, 0, 8'hBC, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hBB, 0, 8'hAA, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hCC, 0, 8'hBB, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'hCC, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'hBC, 0, 0, 0));
        // PAUSE at cnt 6 inserts one idle; PAUSE elsewhere is ignored
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h11, 0, 8'hBC, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 8'h11, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'h22, 0, 8'hBC, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 8'h00, 0, 8'h22, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'hBC, 0, 0, 0));
        // unsolicited FIFO_VALID, then a read left unanswered
        tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 1, 8'hBC, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'hBC, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 8'hBC, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'hBC, 0, 0, 1));
        // fetch F0 (ERR still set from above)
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hF0, 0, 8'hBC, 0, 1, 1));

        idx = 0;
        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset();
            run_period(tbl[k], 8, idx);
            idx++;
        end

        // F0 on the line; reset pulsed at cnt 3 must discard it and clear ERR
        run_period(mk(0, 0, 0, 0, 0, 8'h00, 0, 8'hF0, 1, 0, 1), 3, idx);
        idx++;
        fifo.FIFO_EMPTY = 1'b0;
        PAUSE           = 1'b0;
        fifo.FIFO_VALID = 1'b0;
        #1;
        chk("mid_cnt3", 32'(DBG_CNT), 32'd3);
        chk("mid_serial_f0_bit4", 32'(SERIAL_OUT), 32'd1);
        #2;
        RESET_L = 1'b0;
        #1;
        chk("mid_rst_serial", 32'(SERIAL_OUT), 32'd1);
        chk("mid_rst_active", 32'(DATA_ACTIVE), 32'd0);
        chk("mid_rst_read", 32'(fifo.READ), 32'd0);
        chk("mid_rst_err", 32'(ERR), 32'd0);
        chk("mid_rst_cnt", 32'(DBG_CNT), 32'd0);
        @(negedge CLK);
        RESET_L = 1'b1;

        run_period(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'hBC, 0, 0, 0), 8, idx); idx++;
        run_period(mk(0, 0, 0, 0, 1, 8'h5A, 0, 8'hBC, 0, 1, 0), 8, idx); idx++;
        run_period(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 0), 8, idx); idx++;
        run_period(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'hBC, 0, 0, 0), 8, idx); idx++;

        chk("bytes_left_in_exp_q", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
